// File: rtl/duv_fifo_if.sv
// duv_fifo_if: handshake and status bundle for the duv_fifo byte FIFO.
//
// Signals (named from the FIFO's point of view):
//   duv_fifo_clr_ip        synchronous flush, active-high
//   duv_fifo_in_valid_ip   producer has data
//   duv_fifo_in_data_ip    write data
//   duv_fifo_in_ready_op   FIFO accepts a write this cycle
//   duv_fifo_out_valid_op  head entry valid
//   duv_fifo_out_data_op   head entry (zero when not valid)
//   duv_fifo_out_ready_ip  consumer takes the head
//   duv_fifo_level_op      current occupancy, 0..DEPTH
//   duv_fifo_hwm_op        maximum occupancy since reset/clear
//   duv_fifo_drop_op       sticky: a write was attempted while not ready
//
// Modports:
//   master  producer/consumer/bench side
//   slave   FIFO side
interface duv_fifo_if #(
  parameter int DUV_FIFO_WIDTH_P = 8,
  parameter int DUV_FIFO_DEPTH_P = 8
);
  localparam int AW = $clog2(DUV_FIFO_DEPTH_P);

  logic                        duv_fifo_clr_ip;
  logic                        duv_fifo_in_valid_ip;
  logic [DUV_FIFO_WIDTH_P-1:0] duv_fifo_in_data_ip;
  logic                        duv_fifo_in_ready_op;
  logic                        duv_fifo_out_valid_op;
  logic [DUV_FIFO_WIDTH_P-1:0] duv_fifo_out_data_op;
  logic                        duv_fifo_out_ready_ip;
  logic [AW:0]                 duv_fifo_level_op;
  logic [AW:0]                 duv_fifo_hwm_op;
  logic                        duv_fifo_drop_op;

  modport master (
    output duv_fifo_clr_ip,
    output duv_fifo_in_valid_ip,
    output duv_fifo_in_data_ip,
    input  duv_fifo_in_ready_op,
    input  duv_fifo_out_valid_op,
    input  duv_fifo_out_data_op,
    output duv_fifo_out_ready_ip,
    input  duv_fifo_level_op,
    input  duv_fifo_hwm_op,
    input  duv_fifo_drop_op
  );

  modport slave (
    input  duv_fifo_clr_ip,
    input  duv_fifo_in_valid_ip,
    input  duv_fifo_in_data_ip,
    output duv_fifo_in_ready_op,
    output duv_fifo_out_valid_op,
    output duv_fifo_out_data_op,
    input  duv_fifo_out_ready_ip,
    output duv_fifo_level_op,
    output duv_fifo_hwm_op,
    output duv_fifo_drop_op
  );
endinterface

// File: rtl/duv_fifo.sv
// duv_fifo: synchronous valid/ready FIFO with occupancy, high-water mark and
// a sticky drop flag.
//
// Ports:
//   duv_fifo_clk_ip  clock, all state changes on the rising edge
//   duv_fifo_rst_ip  asynchronous active-low reset (deassertion is already
//                    synchronised upstream)
//   bus              duv_fifo_if.slave: clear, write handshake, read
//                    handshake, level / hwm / drop status
//
// Pointers carry one extra wrap bit so full and empty are distinguishable
// without a separate counter; level is simply their modular difference.
// The storage array is not reset: stale contents are unreachable because the
// pointers are, and the read data is forced to zero whenever empty.
module duv_fifo #(
  parameter int DUV_FIFO_WIDTH_P = 8,
  parameter int DUV_FIFO_DEPTH_P = 8
) (
  input  logic      duv_fifo_clk_ip,
  input  logic      duv_fifo_rst_ip,
  duv_fifo_if.slave bus
);
  localparam int          AW      = $clog2(DUV_FIFO_DEPTH_P);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [DUV_FIFO_WIDTH_P-1:0] mem [DUV_FIFO_DEPTH_P];

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [AW:0] hwm;
  logic [AW:0] level;
  logic [AW:0] level_nxt;
  logic        alive;
  logic        drop;
  logic        full;
  logic        empty;
  logic        in_ready;
  logic        out_valid;
  logic        push;
  logic        pop;
  logic        drop_set;

  function automatic logic [AW:0] f_next_level(input logic [AW:0] cur,
                                               input logic inc,
                                               input logic dec);
    logic [AW:0] r;
    r = cur;
    if (inc && !dec)
      r = cur + PTR_ONE;
    else if (dec && !inc)
      r = cur - PTR_ONE;
    return r;
  endfunction

  function automatic logic [AW:0] f_max(input logic [AW:0] a,
                                        input logic [AW:0] b);
    return (a > b) ? a : b;
  endfunction

  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign level = wr_ptr - rd_ptr;

  // in_ready depends only on local state, never on out_ready, so a full FIFO
  // being popped still refuses the write in that same cycle.
  assign in_ready  = alive & ~full;
  assign out_valid = ~empty;

  // Clear wins over any transfer in its cycle and suppresses drop detection.
  assign push     = bus.duv_fifo_in_valid_ip & in_ready & ~bus.duv_fifo_clr_ip;
  assign pop      = out_valid & bus.duv_fifo_out_ready_ip & ~bus.duv_fifo_clr_ip;
  assign drop_set = bus.duv_fifo_in_valid_ip & ~in_ready & alive &
                    ~bus.duv_fifo_clr_ip;

  assign level_nxt = f_next_level(level, push, pop);

  // Control state: pointers, alive, hwm, drop
  always_ff @(posedge duv_fifo_clk_ip or negedge duv_fifo_rst_ip) begin
    if (!duv_fifo_rst_ip) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      hwm    <= '0;
      drop   <= 1'b0;
      alive  <= 1'b0;
    end else begin
      alive <= 1'b1;
      if (bus.duv_fifo_clr_ip) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        hwm    <= '0;
        drop   <= 1'b0;
      end else begin
        if (push)
          wr_ptr <= wr_ptr + PTR_ONE;
        if (pop)
          rd_ptr <= rd_ptr + PTR_ONE;
        hwm <= f_max(hwm, level_nxt);
        if (drop_set)
          drop <= 1'b1;
      end
    end
  end

  // Storage: data only, no reset
  always_ff @(posedge duv_fifo_clk_ip) begin
    if (push)
      mem[wr_ptr[AW-1:0]] <= bus.duv_fifo_in_data_ip;
  end

  assign bus.duv_fifo_in_ready_op  = in_ready;
  assign bus.duv_fifo_out_valid_op = out_valid;
  assign bus.duv_fifo_out_data_op  = out_valid ? mem[rd_ptr[AW-1:0]] : '0;
  assign bus.duv_fifo_level_op     = level;
  assign bus.duv_fifo_hwm_op       = hwm;
  assign bus.duv_fifo_drop_op      = drop;
endmodule

// File: doc/duv_fifo.md
# duv_fifo

Synchronous valid/ready FIFO. It is the first real design block inside `duv`, clocked by the `sim_ctrl` clock and reset. It buffers a byte stream between a stimulus source and a sink, and reports occupancy, high-water mark and a sticky drop error to the bench. The `example` top drives its reset from the inverted `sim_ctrl` reset output.

## Interface

Parameters:
- `DUV_FIFO_WIDTH_P`, default 8: data width in bits, ≥1.
- `DUV_FIFO_DEPTH_P`, default 8: entry count. Must be a power of two, ≥2. `AW = $clog2(DUV_FIFO_DEPTH_P)`.

Ports:
- `duv_fifo_clk_ip`  input  1  clock; all state changes on its rising edge.
- `duv_fifo_rst_ip`  input  1  asynchronous, active-low reset; asserts asynchronously, deasserts synchronously (source is synchronised upstream).
- `duv_fifo_clr_ip`  input  1  synchronous flush, active-high.
- `duv_fifo_in_valid_ip`  input  1  producer has data.
- `duv_fifo_in_data_ip`  input  WIDTH  write data.
- `duv_fifo_in_ready_op`  output  1  FIFO accepts a write this cycle.
- `duv_fifo_out_valid_op`  output  1  head entry valid.
- `duv_fifo_out_data_op`  output  WIDTH  head entry.
- `duv_fifo_out_ready_ip`  input  1  consumer takes the head.
- `duv_fifo_level_op`  output  AW+1  current occupancy, 0..DEPTH.
- `duv_fifo_hwm_op`  output  AW+1  maximum level since reset/clear.
- `duv_fifo_drop_op`  output  1  sticky: a write was attempted while not ready.

## Operation

State:
- Write and read pointers, AW+1 bits each; the extra bit is the wrap bit.
- Storage array of DEPTH×WIDTH; not reset.
- Alive flop, hwm register, drop flop.

Control:
- `full` = pointers equal except MSB. `empty` = pointers fully equal.
- `level` = wr_ptr − rd_ptr, modulo 2^(AW+1).
- Alive flop: resets to 0 and sets to 1 on the first clock edge after reset deasserts.
- `in_ready_op` = alive & !full. It has no combinational path from `out_ready_ip`.
- `out_valid_op` = !empty.
- `out_data_op` = storage[rd_ptr[AW-1:0]] when `out_valid_op` is high, otherwise all zeros.

Transfers:
- Push = in_valid & in_ready: write the array at wr_ptr, then wr_ptr+1.
- Pop = out_valid & out_ready: rd_ptr+1.
- Push and pop in the same cycle are both performed; level is unchanged.
- Full with a simultaneous pop: in_ready is still 0, so no push occurs. Full-and-pop does not accept a write.
- Drop: if in_valid=1 while in_ready=0 and alive=1, set `drop_op`. The data is discarded. Drop stays set until reset or clear. No drop is flagged while alive=0.
- hwm: the registered maximum of next-level. It updates in the same edge as the level change.

Clear (`clr_ip`=1 at an edge):
- Pointers to 0, hwm to 0, drop to 0.
- Clear has priority over a push or pop in that cycle; both are ignored and no drop is flagged.
- Alive is unaffected.

Reset (`rst_ip`=0, any time including mid-transfer): all state listed below is forced immediately; FIFO contents are lost.

## Timing

Reset values:
- `in_ready_op`=0, `out_valid_op`=0, `out_data_op`=0.
- `level_op`=0, `hwm_op`=0, `drop_op`=0.

Latency and throughput:
- Write to read latency is 1 cycle. Data pushed at edge N is presented with `out_valid_op`=1 after edge N.
- Sustained throughput is 1 transfer per cycle in both directions.
- `level_op` and `hwm_op` reflect edge N results after edge N.
- `drop_op` rises after the edge at which the illegal attempt was sampled.
- Wrap-around: pointer rollover from 2·DEPTH−1 to 0 is natural binary. Full and empty remain correct across any number of wraps.

## Test plan

- **Reset/alive:** hold reset for 5 cycles with in_valid=1 → all outputs 0, drop stays 0; `in_ready_op` rises 1 cycle after release.
- **Fill/drain (DEPTH=8):** push 0x01..0x08 back-to-back → in_ready falls after the 8th push, level=8, hwm=8. A 9th attempt (0xAA) sets drop=1. Pop 8 → data 0x01..0x08 in order, then out_valid=0 and out_data=0.
- **Streaming wrap:** in_valid=out_ready=1 for 40 cycles with an incrementing byte → 39 outputs in order with no gaps, level constant at 1, hwm=1, no drop.
- **Full plus pop:** fill to 8, then assert in_valid and out_ready together → first cycle pops only (level 7). Next cycle accepts the push and pops (level 7). drop=1 from the first cycle.
- **Clear priority:** level=5, hwm=6, drop=1; assert clr with push and pop → next cycle level=0, hwm=0, drop=0, out_valid=0, and the pushed data is absent.
- **Async reset mid-stream:** assert rst between edges at level=4 → outputs reach reset values before the next edge, and the previous contents never reappear after release.
